cmd_frame_parser: RTL and testbench

Byte-stream command decoder that produces the `cmd_vaild` / `cmd_code` / `para_list` command interface consumed by the video zone logic (codes 0xA1 set zone origin, 0xA2 set zone size, 0xA3 enable zoned display). It sits between the UART receiver and the video pipeline, runs in the video clock domain, and turns checksummed 7-byte frames into one-cycle command strobes with persistent code and parameter registers.

---
 rtl/cmd_frame_parser_if.sv | 31 +++
 rtl/cmd_frame_parser.sv | 131 +++++++++++++
 tb/tb_cmd_frame_parser.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_frame_parser_if.sv
// cmd_frame_parser_if
// Groups the byte stream coming from the UART receiver and the command
// interface going to the video zone logic into one bundle.
//   rx_data   : received byte, meaningful only while rx_valid is high
//   rx_valid  : one-cycle strobe per received byte
//   cmd_vaild : one-cycle pulse for a newly accepted command
//   cmd_code  : code of the last accepted command (held)
//   para_list : parameter word of the last accepted command (held)
//   frame_err : one-cycle pulse for a rejected frame
//   busy      : a frame is partially received
// The master modport is the side that supplies bytes and consumes commands;
// the slave modport is the parser itself.
interface cmd_frame_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cmd_vaild;
  logic [7:0]  cmd_code;
  logic [31:0] para_list;
  logic        frame_err;
  logic        busy;

  modport master (
    output rx_data, rx_valid,
    input  cmd_vaild, cmd_code, para_list, frame_err, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output cmd_vaild, cmd_code, para_list, frame_err, busy
  );
endinterface

// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser
// Decodes checksummed 7-byte frames (A5, CMD, P3, P2, P1, P0, CHK) from a
// byte stream into one-cycle command strobes with persistent code and
// parameter registers. Single clock domain (video clock).
//   clk  : video clock
//   rstn : asynchronous active-low reset
//   bus  : cmd_frame_parser_if.slave (byte input, command output)
// Parameter TIMEOUT_CYCLES bounds the idle gap between bytes inside a frame.
module cmd_frame_parser #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rstn,
  cmd_frame_parser_if.slave    bus
);

  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        HEADER  = 8'hA5;

  typedef enum logic [2:0] {IDLE, CMD, P3, P2, P1, P0, CHK} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [7:0]        sum, sum_next;
  logic [7:0]        code_sh, code_sh_next;
  logic [31:0]       para_sh, para_sh_next;
  logic [7:0]        code_q, code_next;
  logic [31:0]       para_q, para_next;
  logic              vaild_q, vaild_next;
  logic              err_q, err_next;
  logic              code_ok;

  assign code_ok = (bus.rx_data == 8'hA1) || (bus.rx_data == 8'hA2) ||
                   (bus.rx_data == 8'hA3);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      sum     <= '0;
      code_sh <= '0;
      para_sh <= '0;
      code_q  <= '0;
      para_q  <= '0;
      vaild_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      sum     <= sum_next;
      code_sh <= code_sh_next;
      para_sh <= para_sh_next;
      code_q  <= code_next;
      para_q  <= para_next;
      vaild_q <= vaild_next;
      err_q   <= err_next;
    end
  end

  // An arriving byte always takes priority over the timeout check, so a
  // byte landing exactly on the last allowed cycle is still accepted.
  // Parameter bytes are shifted in MSB first, giving {P3,P2,P1,P0}.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    sum_next     = sum;
    code_sh_next = code_sh;
    para_sh_next = para_sh;
    code_next    = code_q;
    para_next    = para_q;
    vaild_next   = 1'b0;
    err_next     = 1'b0;

    if (state == IDLE) begin
      cnt_next = '0;
      if (bus.rx_valid && bus.rx_data == HEADER) begin
        state_next = CMD;
        sum_next   = '0;
      end
    end else if (bus.rx_valid) begin
      cnt_next = '0;
      case (state)
        CMD: begin
          if (code_ok) begin
            code_sh_next = bus.rx_data;
            sum_next     = sum + bus.rx_data;
            state_next   = P3;
          end else begin
            err_next   = 1'b1;
            state_next = IDLE;
          end
        end
        P3, P2, P1, P0: begin
          para_sh_next = {para_sh[23:0], bus.rx_data};
          sum_next     = sum + bus.rx_data;
          case (state)
            P3:      state_next = P2;
            P2:      state_next = P1;
            P1:      state_next = P0;
            default: state_next = CHK;
          endcase
        end
        CHK: begin
          if (bus.rx_data == sum) begin
            code_next  = code_sh;
            para_next  = para_sh;
            vaild_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (cnt == CNT_MAX) begin
      err_next   = 1'b1;
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      cnt_next = cnt + 1'b1;
    end
  end

  assign bus.cmd_vaild = vaild_q;
  assign bus.frame_err = err_q;
  assign bus.cmd_code  = code_q;
  assign bus.para_list = para_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_cmd_frame_parser.sv
// tb_cmd_frame_parser
// Directed testbench for cmd_frame_parser with TIMEOUT_CYCLES = 16.
// Inputs are driven 1 time unit after a rising edge and outputs are checked
// at that same point; pulse counters are sampled on falling edges.
module tb_cmd_frame_parser;

  logic clk;
  logic rstn;
  int   total;
  int   bad;
  int   vaild_cnt;
  int   err_cnt;
  int   both_cnt;

  cmd_frame_parser_if bus();

  cmd_frame_parser #(.TIMEOUT_CYCLES(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output pulses away from the active edge
  initial begin
    vaild_cnt = 0;
    err_cnt   = 0;
    both_cnt  = 0;
  end
  always @(negedge clk) begin
    if (bus.cmd_vaild) vaild_cnt++;
    if (bus.frame_err) err_cnt++;
    if (bus.cmd_vaild && bus.frame_err) both_cnt++;
  end

  // Absolute time limit so the run always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one byte for exactly one cycle; starts and ends 1 unit after a rising edge
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] code, input logic [31:0] para, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(code);
    send_byte(para[31:24]);
    send_byte(para[23:16]);
    send_byte(para[15:8]);
    send_byte(para[7:0]);
    send_byte(chk);
  endtask

  task automatic test_reset();
    rstn         = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    idle(3);
    total++; if (bus.cmd_vaild !== 1'b0) begin bad++; $display("[TB] FAIL reset_vaild: got %b want 0", bus.cmd_vaild); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", bus.frame_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.cmd_code !== 8'h00) begin bad++; $display("[TB] FAIL reset_code: got %h want 00", bus.cmd_code); end
    total++; if (bus.para_list !== 32'h0) begin bad++; $display("[TB] FAIL reset_para: got %h want 00000000", bus.para_list); end
    rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_valid_a1();
    int v0, e0;
    v0 = vaild_cnt; e0 = err_cnt;
    send_frame(8'hA1, 32'h00032032, 8'hF6);
    total++; if (bus.cmd_vaild !== 1'b1) begin bad++; $display("[TB] FAIL a1_vaild: got %b want 1", bus.cmd_vaild); end
    total++; if (bus.cmd_code !== 8'hA1) begin bad++; $display("[TB] FAIL a1_code: got %h want a1", bus.cmd_code); end
    total++; if (bus.para_list !== 32'h00032032) begin bad++; $display("[TB] FAIL a1_para: got %h want 00032032", bus.para_list); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL a1_busy: got %b want 0", bus.busy); end
    idle(5);
    total++; if (bus.cmd_code !== 8'hA1) begin bad++; $display("[TB] FAIL a1_code_held: got %h want a1", bus.cmd_code); end
    total++; if (bus.para_list !== 32'h00032032) begin bad++; $display("[TB] FAIL a1_para_held: got %h want 00032032", bus.para_list); end
    total++; if (vaild_cnt - v0 !== 1) begin bad++; $display("[TB] FAIL a1_pulses: got %0d want 1", vaild_cnt - v0); end
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("[TB] FAIL a1_errs: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_garbage_a3();
    int v0, e0;
    v0 = vaild_cnt; e0 = err_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    idle(1);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL garbage_busy: got %b want 0", bus.busy); end
    send_frame(8'hA3, 32'h00000000, 8'hA3);
    total++; if (bus.cmd_vaild !== 1'b1) begin bad++; $display("[TB] FAIL a3_vaild: got %b want 1", bus.cmd_vaild); end
    idle(1000);
    total++; if (bus.cmd_code !== 8'hA3) begin bad++; $display("[TB] FAIL a3_code_held: got %h want a3", bus.cmd_code); end
    total++; if (bus.para_list !== 32'h0) begin bad++; $display("[TB] FAIL a3_para: got %h want 00000000", bus.para_list); end
    total++; if (vaild_cnt - v0 !== 1) begin bad++; $display("[TB] FAIL a3_pulses: got %0d want 1", vaild_cnt - v0); end
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("[TB] FAIL a3_errs: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_bad_checksum();
    int v0, e0;
    send_frame(8'hA1, 32'h00032032, 8'hF6);
    idle(2);
    v0 = vaild_cnt; e0 = err_cnt;
    send_frame(8'hA2, 32'h00000010, 8'h00);
    total++; if (bus.frame_err !== 1'b1) begin bad++; $display("[TB] FAIL chk_err: got %b want 1", bus.frame_err); end
    total++; if (bus.cmd_vaild !== 1'b0) begin bad++; $display("[TB] FAIL chk_vaild: got %b want 0", bus.cmd_vaild); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL chk_busy: got %b want 0", bus.busy); end
    idle(2);
    total++; if (bus.cmd_code !== 8'hA1) begin bad++; $display("[TB] FAIL chk_code: got %h want a1", bus.cmd_code); end
    total++; if (bus.para_list !== 32'h00032032) begin bad++; $display("[TB] FAIL chk_para: got %h want 00032032", bus.para_list); end
    total++; if (vaild_cnt - v0 !== 0) begin bad++; $display("[TB] FAIL chk_pulses: got %0d want 0", vaild_cnt - v0); end
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("[TB] FAIL chk_errs: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_unknown_code();
    send_byte(8'hA5);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL unk_busy_hdr: got %b want 1", bus.busy); end
    send_byte(8'hB0);
    total++; if (bus.frame_err !== 1'b1) begin bad++; $display("[TB] FAIL unk_err: got %b want 1", bus.frame_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL unk_busy: got %b want 0", bus.busy); end
    idle(2);
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'hA1);
    idle(15);
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("[TB] FAIL tmo_early: got %b want 0", bus.frame_err); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL tmo_busy_wait: got %b want 1", bus.busy); end
    idle(1);
    total++; if (bus.frame_err !== 1'b1) begin bad++; $display("[TB] FAIL tmo_err: got %b want 1", bus.frame_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL tmo_busy: got %b want 0", bus.busy); end
    idle(2);
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("[TB] FAIL tmo_errs: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_timeout_edge();
    int e0;
    logic [7:0] bytes [6];
    bytes = '{8'hA2, 8'h12, 8'h34, 8'h56, 8'h78, 8'hB6};
    e0 = err_cnt;
    send_byte(8'hA5);
    for (int i = 0; i < 6; i++) begin
      idle(15);
      send_byte(bytes[i]);
    end
    total++; if (bus.cmd_vaild !== 1'b1) begin bad++; $display("[TB] FAIL edge_vaild: got %b want 1", bus.cmd_vaild); end
    total++; if (bus.para_list !== 32'h12345678) begin bad++; $display("[TB] FAIL edge_para: got %h want 12345678", bus.para_list); end
    total++; if (bus.cmd_code !== 8'hA2) begin bad++; $display("[TB] FAIL edge_code: got %h want a2", bus.cmd_code); end
    idle(1);
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("[TB] FAIL edge_errs: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = vaild_cnt;
    send_frame(8'hA1, 32'h00032032, 8'hF6);
    total++; if (bus.cmd_vaild !== 1'b1) begin bad++; $display("[TB] FAIL b2b_first: got %b want 1", bus.cmd_vaild); end
    send_frame(8'hA3, 32'h00000000, 8'hA3);
    total++; if (bus.cmd_vaild !== 1'b1) begin bad++; $display("[TB] FAIL b2b_second: got %b want 1", bus.cmd_vaild); end
    total++; if (bus.cmd_code !== 8'hA3) begin bad++; $display("[TB] FAIL b2b_code: got %h want a3", bus.cmd_code); end
    idle(2);
    total++; if (vaild_cnt - v0 !== 2) begin bad++; $display("[TB] FAIL b2b_pulses: got %0d want 2", vaild_cnt - v0); end
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'hA2);
    send_byte(8'h01);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL rmf_busy_pre: got %b want 1", bus.busy); end
    rstn = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL rmf_busy: got %b want 0", bus.busy); end
    total++; if (bus.cmd_code !== 8'h00) begin bad++; $display("[TB] FAIL rmf_code: got %h want 00", bus.cmd_code); end
    idle(3);
    total++; if (bus.para_list !== 32'h0) begin bad++; $display("[TB] FAIL rmf_para: got %h want 00000000", bus.para_list); end
    total++; if (bus.cmd_vaild !== 1'b0) begin bad++; $display("[TB] FAIL rmf_vaild: got %b want 0", bus.cmd_vaild); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("[TB] FAIL rmf_err_lvl: got %b want 0", bus.frame_err); end
    rstn = 1'b1;
    idle(2);
    v0 = vaild_cnt;
    send_frame(8'hA2, 32'h0005000A, 8'hB1);
    total++; if (bus.cmd_vaild !== 1'b1) begin bad++; $display("[TB] FAIL rmf_vaild2: got %b want 1", bus.cmd_vaild); end
    total++; if (bus.cmd_code !== 8'hA2) begin bad++; $display("[TB] FAIL rmf_code2: got %h want a2", bus.cmd_code); end
    total++; if (bus.para_list !== 32'h0005000A) begin bad++; $display("[TB] FAIL rmf_para2: got %h want 0005000a", bus.para_list); end
    idle(2);
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("[TB] FAIL rmf_errs: got %0d want 0", err_cnt - e0); end
    total++; if (vaild_cnt - v0 !== 1) begin bad++; $display("[TB] FAIL rmf_pulses: got %0d want 1", vaild_cnt - v0); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_valid_a1();
    test_garbage_a3();
    test_bad_checksum();
    test_unknown_code();
    test_timeout();
    test_timeout_edge();
    test_back_to_back();
    test_reset_mid_frame();
    total++; if (both_cnt !== 0) begin bad++; $display("[TB] FAIL overlap: got %0d want 0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
